// File: rtl/control_unit.sv
// control_unit: registered ALU control decoder for R-type MIPS funct fields.
// Rev 1.0 - initial release.
`default_nettype none

module control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic       instr_valid,
   input  logic [5:0] function_code,
   output logic [2:0] select_bits_ALU,
   output logic       alu_arith_shift,
   output logic       ovf_check_en,
   output logic       reg_write,
   output logic       illegal_funct
);

   localparam logic [5:0] c_funct_and  = 6'b100100;
   localparam logic [5:0] c_funct_or   = 6'b100101;
   localparam logic [5:0] c_funct_add  = 6'b100000;
   localparam logic [5:0] c_funct_addu = 6'b100001;
   localparam logic [5:0] c_funct_nor  = 6'b100111;
   localparam logic [5:0] c_funct_sub  = 6'b100010;
   localparam logic [5:0] c_funct_subu = 6'b100011;
   localparam logic [5:0] c_funct_sltu = 6'b101011;
   localparam logic [5:0] c_funct_srl  = 6'b000010;
   localparam logic [5:0] c_funct_sra  = 6'b000011;
   localparam logic [5:0] c_funct_sll  = 6'b000000;

   localparam logic [2:0] c_sel_and   = 3'b000;
   localparam logic [2:0] c_sel_or    = 3'b001;
   localparam logic [2:0] c_sel_add   = 3'b010;
   localparam logic [2:0] c_sel_nor   = 3'b011;
   localparam logic [2:0] c_sel_sub   = 3'b100;
   localparam logic [2:0] c_sel_sltu  = 3'b101;
   localparam logic [2:0] c_sel_shr   = 3'b110;
   localparam logic [2:0] c_sel_sll   = 3'b111;

   logic [2:0] sel_d, sel_q;
   logic       arith_d, arith_q;
   logic       ovf_d, ovf_q;
   logic       wr_d, wr_q;
   logic       ill_d, ill_q;

   // Select and shift type hold while idle so the ALU operand path stays quiet.
   always_comb begin
      sel_d   = sel_q;
      arith_d = arith_q;
      ovf_d   = 1'b0;
      wr_d    = 1'b0;
      ill_d   = 1'b0;
      if (instr_valid) begin
         sel_d   = c_sel_and;
         arith_d = 1'b0;
         wr_d    = 1'b1;
         case (function_code)
            c_funct_and:  sel_d = c_sel_and;
            c_funct_or:   sel_d = c_sel_or;
            c_funct_add:  begin sel_d = c_sel_add; ovf_d = 1'b1; end
            c_funct_addu: sel_d = c_sel_add;
            c_funct_nor:  sel_d = c_sel_nor;
            c_funct_sub:  begin sel_d = c_sel_sub; ovf_d = 1'b1; end
            c_funct_subu: sel_d = c_sel_sub;
            c_funct_sltu: sel_d = c_sel_sltu;
            c_funct_srl:  sel_d = c_sel_shr;
            c_funct_sra:  begin sel_d = c_sel_shr; arith_d = 1'b1; end
            c_funct_sll:  sel_d = c_sel_sll;
            // Unknown or X funct lands here and is flagged rather than masked.
            default: begin
               wr_d  = 1'b0;
               ill_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q   <= 3'b000;
         arith_q <= 1'b0;
         ovf_q   <= 1'b0;
         wr_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         arith_q <= arith_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         ill_q   <= ill_d;
      end
   end

   assign select_bits_ALU = sel_q;
   assign alu_arith_shift = arith_q;
   assign ovf_check_en    = ovf_q;
   assign reg_write       = wr_q;
   assign illegal_funct   = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven scoreboard bench for control_unit.
`default_nettype none

module tb_control_unit;

   logic       clk;
   logic       reset;
   logic       instr_valid;
   logic [5:0] function_code;
   logic [2:0] select_bits_ALU;
   logic       alu_arith_shift;
   logic       ovf_check_en;
   logic       reg_write;
   logic       illegal_funct;

   control_unit dut (
      .clk             (clk),
      .reset           (reset),
      .instr_valid     (instr_valid),
      .function_code   (function_code),
      .select_bits_ALU (select_bits_ALU),
      .alu_arith_shift (alu_arith_shift),
      .ovf_check_en    (ovf_check_en),
      .reg_write       (reg_write),
      .illegal_funct   (illegal_funct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] sel;
      logic       ash;
      logic       ovf;
      logic       rw;
      logic       ill;
   } outs_t;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [5:0] f;
      outs_t      exp;
   } vec_t;

   localparam int c_nvec = 26;
   vec_t  vecs [c_nvec];
   outs_t exp_q [$];
   int    n_cmp;
   int    n_bad;

   function automatic vec_t mk(input logic rst, input logic v, input logic [5:0] f,
                               input logic [2:0] sel, input logic ash, input logic ovf,
                               input logic rw, input logic ill);
      vec_t r;
      r.rst = rst; r.v = v; r.f = f;
      r.exp.sel = sel; r.exp.ash = ash; r.exp.ovf = ovf; r.exp.rw = rw; r.exp.ill = ill;
      return r;
   endfunction

   function automatic outs_t actual();
      outs_t a;
      a.sel = select_bits_ALU; a.ash = alu_arith_shift; a.ovf = ovf_check_en;
      a.rw = reg_write; a.ill = illegal_funct;
      return a;
   endfunction

   task automatic compare(input string name, input outs_t exp);
      outs_t act;
      act = actual();
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got sel=%b ash=%b ovf=%b rw=%b ill=%b, want sel=%b ash=%b ovf=%b rw=%b ill=%b",
                  name, act.sel, act.ash, act.ovf, act.rw, act.ill,
                  exp.sel, exp.ash, exp.ovf, exp.rw, exp.ill);
      end
   endtask

   task automatic check_pop(input string name);
      outs_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty, got sel=%b, want an expected entry", name, select_bits_ALU);
      end else begin
         e = exp_q.pop_front();
         compare(name, e);
      end
   endtask

   task automatic apply(input vec_t vv, input string name);
      reset         = vv.rst;
      instr_valid   = vv.v;
      function_code = vv.f;
      exp_q.push_back(vv.exp);
      @(posedge clk);
      #1;
      check_pop(name);
   endtask

   initial begin
      outs_t e;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      instr_valid = 1'b0;
      function_code = 6'b000000;

      //             rst   v     funct      sel    ash   ovf   rw    ill
      vecs[0]  = mk(1'b1, 1'b1, 6'b100000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b1, 1'b1, 6'b100000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 1'b1, 6'b100000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0);
      vecs[3]  = mk(1'b0, 1'b1, 6'b100100, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[4]  = mk(1'b0, 1'b1, 6'b100101, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[5]  = mk(1'b0, 1'b1, 6'b100000, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0);
      vecs[6]  = mk(1'b0, 1'b1, 6'b100001, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[7]  = mk(1'b0, 1'b1, 6'b100010, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
      vecs[8]  = mk(1'b0, 1'b1, 6'b100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[9]  = mk(1'b0, 1'b1, 6'b101011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[10] = mk(1'b0, 1'b1, 6'b000011, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[11] = mk(1'b0, 1'b1, 6'b000010, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[12] = mk(1'b0, 1'b1, 6'b000000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[13] = mk(1'b0, 1'b1, 6'b100111, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0);
      // illegal codes
      vecs[14] = mk(1'b0, 1'b1, 6'b001000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      vecs[15] = mk(1'b0, 1'b1, 6'b111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      // valid gating: select and shift type hold
      vecs[16] = mk(1'b0, 1'b1, 6'b101011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[17] = mk(1'b0, 1'b0, 6'b100100, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[18] = mk(1'b0, 1'b1, 6'b000011, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[19] = mk(1'b0, 1'b0, 6'b100000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
      vecs[20] = mk(1'b0, 1'b1, 6'b100010, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
      vecs[21] = mk(1'b0, 1'b0, 6'b000011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      // reset mid-stream
      vecs[22] = mk(1'b0, 1'b1, 6'b100101, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[23] = mk(1'b1, 1'b1, 6'b100000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[24] = mk(1'b0, 1'b1, 6'b100010, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
      vecs[25] = mk(1'b0, 1'b1, 6'b000000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);

      @(posedge clk);
      #1;
      for (int i = 0; i < c_nvec; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // latency: a mid-cycle funct change must not reach the outputs before the edge
      apply(mk(1'b0, 1'b1, 6'b100010, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0), "lat_sub");
      function_code = 6'b000011;
      e = '{sel: 3'b110, ash: 1'b1, ovf: 1'b0, rw: 1'b1, ill: 1'b0};
      exp_q.push_back(e);
      #3;
      compare("lat_hold_mid", '{sel: 3'b100, ash: 1'b0, ovf: 1'b1, rw: 1'b1, ill: 1'b0});
      @(negedge clk);
      #1;
      compare("lat_hold_late", '{sel: 3'b100, ash: 1'b0, ovf: 1'b1, rw: 1'b1, ill: 1'b0});
      @(posedge clk);
      #1;
      check_pop("lat_sra");

      // idle while leaving an illegal code on the bus: flags clear, select holds 000
      apply(mk(1'b0, 1'b1, 6'b111110, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1), "ill_again");
      apply(mk(1'b0, 1'b0, 6'b111110, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0), "ill_idle");

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- ALU control decoder for the single-cycle R-type MIPS datapath.
- Takes the 6-bit R-type function field (instr[5:0]) and produces the 3-bit ALU operation select plus companion control flags for the ALU and the register file.
- All outputs are registered: one clock of latency, synchronous active-high reset.
- Sits between the instruction register and the ALU / write-back stage.

Parameters:
- None. All widths are fixed: 6-bit function code, 3-bit ALU select.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all outputs
- instr_valid  input  1  function_code carries a real instruction this cycle
- function_code  input  6  R-type funct field
- select_bits_ALU  output  3  ALU operation select (registered)
- alu_arith_shift  output  1  1 = right shift is arithmetic (SRA), 0 = logical (registered)
- ovf_check_en  output  1  ALU overflow trap enabled, signed add/sub only (registered)
- reg_write  output  1  write result to rd (registered)
- illegal_funct  output  1  valid instruction with an unsupported funct (registered)

Behaviour:
- Reset: on a rising clk edge with reset=1, every output goes to 0 (select_bits_ALU=3'b000). Reset has priority over instr_valid.
- Latency: outputs reflect the function_code/instr_valid sampled at the previous rising edge. There is no combinational path from input to output.
- Decode table (funct -> select, arith_shift, ovf_check_en):
  - 100100 AND  -> 000, 0, 0
  - 100101 OR   -> 001, 0, 0
  - 100000 ADD  -> 010, 0, 1
  - 100001 ADDU -> 010, 0, 0
  - 100111 NOR  -> 011, 0, 0
  - 100010 SUB  -> 100, 0, 1
  - 100011 SUBU -> 100, 0, 0
  - 101011 SLTU -> 101, 0, 0
  - 000010 SRL  -> 110, 0, 0
  - 000011 SRA  -> 110, 1, 0
  - 000000 SLL  -> 111, 0, 0
- Supported funct with instr_valid=1:
  - reg_write=1, illegal_funct=0.
  - Other outputs per the decode table.
- Unsupported funct (any code not listed) with instr_valid=1:
  - select_bits_ALU=000, alu_arith_shift=0, ovf_check_en=0.
  - reg_write=0, illegal_funct=1.
- instr_valid=0:
  - reg_write=0, illegal_funct=0, ovf_check_en=0.
  - select_bits_ALU and alu_arith_shift hold their previous values, so the ALU input does not toggle.
- Funct 000000 (SLL; also the NOP encoding) is decoded as a legal SLL. NOP suppression is not this block's job.
- Back-to-back instructions: a new decode every cycle, no stalls, no internal state besides the output registers.
- Reset asserted mid-stream: outputs clear on that edge. The first valid instruction after reset deassertion appears one cycle later.
- Any X on function_code while instr_valid=1 must not be masked in simulation; the default branch drives the illegal encoding.

Test Plan:
- Reset: hold reset=1 for 2 cycles with instr_valid=1, funct=100000 -> all outputs 0 on both cycles; release reset -> next edge gives select=010, ovf_check_en=1, reg_write=1.
- Full sweep: apply 100100, 100101, 100000, 100001, 100010, 100011, 101011, 000011, 000010, 000000, 100111 on consecutive cycles with instr_valid=1 -> one cycle later each select is respectively 000, 001, 010, 010, 100, 100, 101, 110, 110, 111, 011; alu_arith_shift=1 only for 000011; ovf_check_en=1 only for 100000 and 100010; reg_write=1 throughout.
- Illegal code: funct=001000 (JR) then 111111 with instr_valid=1 -> illegal_funct=1, reg_write=0, select=000 on each.
- Valid gating: decode 101011 (select=101), then instr_valid=0 with funct=100100 -> select stays 101, reg_write=0, illegal_funct=0, ovf_check_en=0.
- Latency check: change funct from 100010 to 000011 mid-cycle -> outputs change only at the next rising edge (select 100 -> 110, alu_arith_shift 0 -> 1), never between edges.
- Reset mid-operation: during the sweep, assert reset for 1 cycle -> outputs 0 on that edge, and decode resumes correctly on the following edge.
